// File: rtl/fixed_point_dispatch.sv
// Issue/writeback stage in front of the fixed-point unit: holds one instruction on the
// FPU inputs, decides completion from op class, elapsed cycles and fpu_ready, buffers the result.
module fixed_point_dispatch #(
  parameter int WIDTH           = 32,
  parameter int FBITS           = 10,
  parameter int MUL_MIN_CYCLES  = 6,
  parameter int SQRT_MIN_CYCLES = 24,
  parameter int TIMEOUT         = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [4:0]       in_rd,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_SQRT = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  if (FBITS >= WIDTH || TIMEOUT <= MUL_MIN_CYCLES || TIMEOUT <= SQRT_MIN_CYCLES) begin : g_bad_params
    $error("fixed_point_dispatch: inconsistent parameters");
  end

  state_e        state;
  op_e           op_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;
  logic          done;
  logic          timed_out;

  assign fpu_operation = op_q;
  assign busy          = (state != S_IDLE);
  assign in_ready      = (state == S_IDLE) && !reset;

  // Minimum wait masks an fpu_ready left high by the previous operation.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB: done = 1'b1;
      OP_MUL:         done = fpu_ready && (cnt >= CW'(MUL_MIN_CYCLES));
      OP_SQRT:        done = fpu_ready && (cnt >= CW'(SQRT_MIN_CYCLES));
      default:        done = 1'b0;
    endcase
    if (!done && (op_q == OP_MUL || op_q == OP_SQRT) && cnt == CW'(TIMEOUT))
      timed_out = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears
  // every register here, which is cheap since there is no memory array in this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      op_q          <= OP_ADD;
      rd_q          <= '0;
      cnt           <= '0;
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            fpu_operand_1 <= in_rs1;
            fpu_operand_2 <= in_rs2;
            op_q          <= op_e'(in_op);
            rd_q          <= in_rd;
            cnt           <= '0;
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
          if (timed_out) timeout_err <= 1'b1;
          if (done || timed_out) begin
            // Writes to x0 are dropped without a writeback handshake.
            if (rd_q != 5'd0) begin
              wb_data  <= done ? fpu_result : '0;
              wb_rd    <= rd_q;
              wb_valid <= 1'b1;
              state    <= S_WB;
            end else begin
              state    <= S_IDLE;
            end
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_dispatch.sv
// Scoreboard bench for fixed_point_dispatch: a driver issues randomized and directed ops and
// queues expected writebacks; a monitor checks each writeback as the DUT presents it.
module tb_fixed_point_dispatch;

  localparam int W = 32, TO = 64, MUL_MIN = 6, SQRT_MIN = 24;
  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, SQRT = 2'd3;

  logic         clk = 1'b0, reset = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [1:0]   in_op = '0;
  logic [W-1:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0]   in_rd = '0;
  logic [W-1:0] fpu_operand_1, fpu_operand_2, fpu_result = '0;
  logic [1:0]   fpu_operation;
  logic         fpu_ready = 1'b0;
  logic         wb_valid, wb_ready = 1'b1;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         busy, timeout_err;

  fixed_point_dispatch #(.WIDTH(W), .FBITS(10), .MUL_MIN_CYCLES(MUL_MIN),
                         .SQRT_MIN_CYCLES(SQRT_MIN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .fpu_operand_1(fpu_operand_1),
    .fpu_operand_2(fpu_operand_2), .fpu_operation(fpu_operation), .fpu_result(fpu_result),
    .fpu_ready(fpu_ready), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; bit to; } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  bit sticky = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic in Q.10 fixed point.
  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     begin p = {32'b0, a} * {32'b0, b}; return 32'(p >> 10); end
      default: return 32'(isqrt({22'b0, a, 10'b0}));
    endcase
  endfunction

  // Cycle (edges after accept) at which the op finishes, and whether it times out.
  task automatic expect_done(input logic [1:0] op, input int lat, input int stale,
                             output int e, output bit to);
    int mn;
    to = 0;
    if (op == ADD || op == SUB) begin e = 1; return; end
    mn = (op == MUL) ? MUL_MIN : SQRT_MIN;
    for (int k = mn; k <= TO; k++)
      if (k < stale || k >= lat) begin e = k + 1; return; end
    to = 1;
    e  = TO + 1;
  endtask

  // FPU model: ready (with the right result) lat cycles after accept; optionally a stale
  // ready with a garbage result during the first few cycles.
  int acc_a = -1000, lat_l = 0, stale_s = 0;
  always @(posedge clk) begin : fpu_model
    int d;
    #2;
    d = cyc - acc_a;
    fpu_ready  = (d >= 0 && d < stale_s) || (d >= lat_l);
    fpu_result = (d >= lat_l) ? ref_fn(fpu_operation, fpu_operand_1, fpu_operand_2)
                              : (32'hBAD0_0BAD ^ 32'(d));
  end

  int hold_cnt = 0, rdy_pct = 100;
  always @(posedge clk) begin
    #3;
    if (hold_cnt > 0) begin wb_ready = 1'b0; hold_cnt--; end
    else wb_ready = ($urandom_range(99) < rdy_pct);
  end

  logic [31:0] exp_op1 = '0, exp_op2 = '0;
  logic [1:0]  exp_op = ADD;

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input int stale);
    int e, budget;
    bit to;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    budget = 300;
    while (!in_ready && budget > 0) begin @(negedge clk); budget--; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: in_ready never rose within 300 cycles");
      in_valid = 1'b0;
      return;
    end
    acc_a = cyc + 1; lat_l = lat; stale_s = stale;
    exp_op1 = a; exp_op2 = b; exp_op = op;
    expect_done(op, lat, stale, e, to);
    sticky |= to;
    if (rd != 5'd0) q.push_back('{rd, to ? 32'd0 : ref_fn(op, a, b), acc_a + e, sticky});
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'($urandom);
  endtask

  // Monitor: pops an expectation on each new writeback and checks it stays stable.
  logic        prev_v = 1'b0;
  logic [4:0]  h_rd;
  logic [31:0] h_data;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) prev_v = 1'b0;
    else begin
      if (busy) begin
        check("fpu_operand_1_stable", fpu_operand_1, exp_op1);
        check("fpu_operand_2_stable", fpu_operand_2, exp_op2);
        check("fpu_operation_stable", fpu_operation, exp_op);
      end
      if (wb_valid) begin
        check("in_ready_in_wb", in_ready, 1'b0);
        if (!prev_v) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_wb: wb_rd=%0d wb_data=0x%0h with empty scoreboard", wb_rd, wb_data);
          end else begin
            e = q.pop_front();
            check("wb_rd", wb_rd, e.rd);
            check("wb_data", wb_data, e.data);
            check("wb_cycle", cyc, e.cyc);
            check("timeout_err", timeout_err, e.to);
          end
          h_rd = wb_rd; h_data = wb_data;
        end else begin
          check("wb_rd_held", wb_rd, h_rd);
          check("wb_data_held", wb_data, h_data);
        end
        prev_v = !wb_ready;
      end else begin
        if (prev_v) check("wb_valid_held", wb_valid, 1'b1);
        prev_v = 1'b0;
      end
    end
  end

  task automatic drain();
    int budget = 600;
    while (q.size() != 0 && budget > 0) begin @(negedge clk); budget--; end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    logic [1:0] op;
    int lat;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fpu_operand_1", fpu_operand_1, 32'd0);
    check("rst_fpu_operation", fpu_operation, ADD);
    check("rst_timeout_err", timeout_err, 1'b0);
    @(negedge clk) reset = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1'b1);

    issue(ADD, 32'h600, 32'h900, 5'd5, 0, 0);        // 1.5 + 2.25 = 3.75
    issue(MUL, 32'h600, 32'h900, 5'd9, 6, 3);        // stale ready, 3.375
    issue(SQRT, 32'h1000, 32'hFFFF, 5'd12, 30, 2);   // sqrt(4.0) = 2.0
    issue(SQRT, 32'h1000, 32'h0, 5'd3, 1000, 0);     // timeout
    hold_cnt = 8;
    issue(ADD, 32'h123, 32'h456, 5'd7, 0, 0);        // writeback stalled
    issue(SUB, 32'h900, 32'h600, 5'd8, 0, 0);        // waits for the handshake
    issue(ADD, 32'h1, 32'h2, 5'd0, 0, 0);            // x0: discarded
    issue(ADD, 32'h40, 32'h40, 5'd1, 0, 0);
    drain();

    rdy_pct = 60;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(3));
      lat = 0;
      if (op == MUL)  lat = $urandom_range(0, 12);
      if (op == SQRT) lat = $urandom_range(0, 34);
      if (op[1] && $urandom_range(9) == 0) lat = 100;
      issue(op, $urandom_range(0, 32'hFFFFF), $urandom_range(0, 32'hFFFFF),
            5'($urandom_range(31)), lat, $urandom_range(0, 5));
    end
    drain();

    // Reset in the middle of a MUL.
    issue(MUL, 32'h3, 32'h4, 5'd7, 1000, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_wb_valid", wb_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_timeout_err", timeout_err, 1'b0);
    q.delete();
    sticky = 0;
    @(negedge clk) reset = 1'b0;
    #1 check("in_ready_after_midrst", in_ready, 1'b1);
    issue(ADD, 32'h600, 32'h900, 5'd4, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
